gte_sequencer: RTL and testbench
================================

GTE_SEQUENCER -- requirements
Module: gte_sequencer

Interface
REQ-001 Parameter PC_W, default 9, microcode PC width.
REQ-002 Parameter QDEPTH, default 2, instruction queue depth; legal values 1, 2, 4, 8.
REQ-003 Parameter MVMVA_OP, default 6'h12, opcode that sets o_isMVMVA.
REQ-004 Ports: i_clk in 1 clock; i_nRst in 1 reset, asynchronous active-low (one clock domain).
REQ-005 i_instr in 25 GTE command word; i_run in 1 command valid; o_ready out 1 queue can accept.
REQ-006 o_opcode out 6 opcode of the next-to-dispatch command, to the start-address ROM; i_startAdr in PC_W, combinational return.
REQ-007 i_lastMicro in 1 current microword is the last; i_stall in 1 hold PC; i_abort in 1 flush.
REQ-008 o_PC out PC_W zero-latency microcode address (pre-register value).
REQ-009 o_sf, o_lm out 1; o_cv, o_vec, o_mx out 2 each; o_isMVMVA out 1: latched command fields.
REQ-010 o_executing out 1 busy flag; o_lastCycles out 16 duration of the last instruction (see Configuration).

Function
REQ-011 Queue: FIFO of QDEPTH 25-bit words; push = i_run & o_ready; o_ready = (registered count < QDEPTH); a pop in the same cycle gives no extra credit.
REQ-012 Two states: IDLE and EXEC.
REQ-013 Next-command source: queue head if the queue is non-empty, else i_instr when i_run (bypass, not pushed); o_opcode = source[5:0].
REQ-014 Dispatch occurs when a source exists and either (IDLE) or (EXEC & i_lastMicro & !i_stall).
REQ-015 On dispatch: o_PC = i_startAdr same cycle; fields latched at the clock edge (sf=[19], lm=[10], cv=[14:13], vec=[16:15], mx=[18:17], isMVMVA = [5:0]==MVMVA_OP); state -> EXEC; pop if source is the queue.
REQ-016 IDLE with no source: o_PC = 0 (NOP entry).
REQ-017 EXEC & i_stall: o_PC = PC (hold); i_stall overrides i_lastMicro.
REQ-018 EXEC & !i_stall & !i_lastMicro: o_PC = PC+1, wrapping modulo 2^PC_W.
REQ-019 EXEC & i_lastMicro & !i_stall & no source: o_PC = 0, state -> IDLE.
REQ-020 Back-to-back dispatch on i_lastMicro gives zero idle cycles between commands.
REQ-021 o_executing = (state==EXEC | queue non-empty), cleared combinationally in the completing cycle when no source exists.
REQ-022 Latched fields hold between dispatches, including through IDLE.
REQ-023 Simultaneous push and pop, not full: count unchanged, FIFO order kept.
REQ-024 i_abort (priority over all): o_PC = 0 that cycle; queue emptied; state -> IDLE; same-cycle i_run is neither pushed nor dispatched; latched fields unchanged.

Reset
REQ-025 On i_nRst low, asynchronously: state IDLE, PC 0, queue empty, all latched fields 0, o_lastCycles 0.
REQ-026 While i_nRst is low: o_PC = 0, o_ready = 0, o_executing = 0.
REQ-027 Reset mid-instruction discards the running and queued commands with no completion side effects.

Configuration
REQ-028 Macro GTE_SEQ_PERFCNT_EN defined: a 16-bit counter counts every EXEC cycle, including stall cycles. On completion (finishing or back-to-back), o_lastCycles = count, saturating at 16'hFFFF, and is updated at that edge. The counter restarts at 1 for a back-to-back command. Abort does not update o_lastCycles.
REQ-029 Macro GTE_SEQ_PERFCNT_EN undefined: no counter logic; o_lastCycles tied to 0.

Verification
REQ-030 Idle, i_run with opcode 6'h01, i_startAdr=9'h040, program completes 4 microwords later -> o_PC=040 same cycle, then 041, 042, 043, 000; o_executing falls in the 043 cycle.
REQ-031 QDEPTH=2: three i_run pulses while executing -> first two pushed, third sees o_ready=0; commands dispatch back-to-back in order with no PC=0 gap.
REQ-032 i_stall high for 3 cycles at PC=9'h041 with i_lastMicro also high -> o_PC holds 041 for 3 cycles, then advances; with PERFCNT o_lastCycles = microwords + 3.
REQ-033 Opcode 6'h12 with bits[18:13]=6'b101101 -> o_isMVMVA=1, mx=2'b10, vec=2'b11, cv=2'b01; the next non-MVMVA dispatch clears o_isMVMVA.
REQ-034 i_abort with 2 queued commands and concurrent i_run -> o_PC=0 that cycle, next cycle IDLE, queue empty, o_ready=1, o_executing=0.
REQ-035 PC_W=4, program starting at 4'hF not yet last -> o_PC wraps to 4'h0; async reset asserted mid-run -> all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/gte_sequencer.sv
// gte_sequencer: GTE command queue and microcode program-counter sequencer.
// Accepts 25-bit command words into a small FIFO. It dispatches them to the
// microcode ROM through the start-address lookup and then steps the PC until
// the microcode signals its last word.
// Optional feature: define GTE_SEQ_PERFCNT_EN to enable the per-instruction
// cycle counter reported on o_lastCycles. When it is undefined, o_lastCycles
// is tied to zero.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no command running; o_PC shows the NOP entry (0)
// EXEC  | a command is running; pc_q is the address of the current word

module gte_sequencer #(
  parameter int unsigned PC_W     = 9,
  parameter int unsigned QDEPTH   = 2,
  parameter logic [5:0]  MVMVA_OP = 6'h12
) (
  input  logic            i_clk,
  input  logic            i_nRst,
  input  logic [24:0]     i_instr,
  input  logic            i_run,
  output logic            o_ready,
  output logic [5:0]      o_opcode,
  input  logic [PC_W-1:0] i_startAdr,
  input  logic            i_lastMicro,
  input  logic            i_stall,
  input  logic            i_abort,
  output logic [PC_W-1:0] o_PC,
  output logic            o_sf,
  output logic            o_lm,
  output logic [1:0]      o_cv,
  output logic [1:0]      o_vec,
  output logic [1:0]      o_mx,
  output logic            o_isMVMVA,
  output logic            o_executing,
  output logic [15:0]     o_lastCycles
);

  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QDEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QDEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;

  logic [24:0]      mem_q [QDEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             sf_q, lm_q, mvmva_q;
  logic [1:0]       cv_q, vec_q, mx_q;

  logic             q_empty;
  logic             ready_int;
  logic             has_src;
  logic [24:0]      src;
  logic             done;
  logic             dispatch;
  logic             push;
  logic             pop;
  logic             unused_src_bits;

  // Queue status, next-command source selection and dispatch decision
  always_comb begin
    q_empty   = (count_q == '0);
    ready_int = (count_q < CNT_FULL);
    has_src   = !q_empty || i_run;
    src       = q_empty ? i_instr : mem_q[rd_ptr_q];
    done      = (state_q == EXEC) && i_lastMicro && !i_stall;
    dispatch  = !i_abort && has_src && ((state_q == IDLE) || done);
    pop       = dispatch && !q_empty;
    // A command taken straight from i_instr as a bypass is not also queued.
    push      = !i_abort && i_run && ready_int && !(dispatch && q_empty);
  end

  assign unused_src_bits = ^{src[24:20], src[12:11], src[9:6]};

  assign o_opcode    = src[5:0];
  assign o_ready     = i_nRst && ready_int;
  assign o_executing = i_nRst &&
                       (((state_q == EXEC) && !(done && !has_src)) || !q_empty);
  assign o_PC        = i_nRst ? pc_d : '0;

  // Next state and zero-latency PC selection
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (i_abort) begin
      state_d = IDLE;
      pc_d    = '0;
    end else if (dispatch) begin
      state_d = EXEC;
      pc_d    = i_startAdr;
    end else begin
      case (state_q)
        IDLE: pc_d = '0;
        EXEC: begin
          if (i_stall) begin
            pc_d = pc_q;
          end else if (!i_lastMicro) begin
            pc_d = pc_q + PC_W'(1);
          end else begin
            pc_d    = '0;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          pc_d    = '0;
        end
      endcase
    end
  end

  // State and PC registers
  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Queue pointer and occupancy update; abort flushes everything
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (i_abort) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue pointer and occupancy registers
  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage; data only, validity is tracked by count_q
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_instr;
    end
  end

  // Command fields captured at dispatch and held until the next one
  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      sf_q    <= 1'b0;
      lm_q    <= 1'b0;
      cv_q    <= 2'b00;
      vec_q   <= 2'b00;
      mx_q    <= 2'b00;
      mvmva_q <= 1'b0;
    end else if (dispatch) begin
      sf_q    <= src[19];
      lm_q    <= src[10];
      cv_q    <= src[14:13];
      vec_q   <= src[16:15];
      mx_q    <= src[18:17];
      mvmva_q <= (src[5:0] == MVMVA_OP);
    end
  end

  assign o_sf      = sf_q;
  assign o_lm      = lm_q;
  assign o_cv      = cv_q;
  assign o_vec     = vec_q;
  assign o_mx      = mx_q;
  assign o_isMVMVA = mvmva_q;

`ifdef GTE_SEQ_PERFCNT_EN
  logic [15:0] cyc_q, cyc_d;
  logic [15:0] last_q, last_d;

  // Cycle count of the running command; cyc_q is 1 in its first EXEC cycle
  always_comb begin
    cyc_d  = cyc_q;
    last_d = last_q;
    if (done && !i_abort) begin
      last_d = cyc_q;
    end
    if (dispatch) begin
      cyc_d = 16'd1;
    end else if ((state_q == EXEC) && !done && (cyc_q != 16'hFFFF)) begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      cyc_q  <= '0;
      last_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      last_q <= last_d;
    end
  end

  assign o_lastCycles = last_q;
`else
  assign o_lastCycles = 16'h0000;
`endif

endmodule

// File: tb/tb_gte_sequencer.sv
// tb_gte_sequencer: directed stimulus with a queue-based reference model
// checked every cycle, plus literal expectations for the key scenarios.
// A second instance with PC_W=4 shares the stimulus to exercise PC wrap.
`timescale 1ns/1ps

module tb_gte_sequencer;

  localparam int QDEPTH = 2;

  logic        i_clk = 1'b0;
  logic        i_nRst = 1'b0;
  logic [24:0] i_instr = '0;
  logic        i_run = 1'b0;
  logic        i_lastMicro = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_abort = 1'b0;
  logic [8:0]  start_adr;

  logic        o_ready, o_sf, o_lm, o_isMVMVA, o_executing;
  logic [5:0]  o_opcode;
  logic [8:0]  o_PC;
  logic [1:0]  o_cv, o_vec, o_mx;
  logic [15:0] o_lastCycles;

  logic        w4_ready, w4_sf, w4_lm, w4_isMVMVA, w4_executing;
  logic [5:0]  w4_opcode;
  logic [3:0]  w4_PC;
  logic [1:0]  w4_cv, w4_vec, w4_mx;
  logic [15:0] w4_lastCycles;

  int n_chk = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  function automatic logic [8:0] rom(input logic [5:0] op);
    case (op)
      6'h01:   return 9'h040;
      6'h12:   return 9'h100;
      6'h3F:   return 9'h1FF;
      default: return {op, 3'b101};
    endcase
  endfunction

  assign start_adr = rom(o_opcode);

  gte_sequencer #(.PC_W(9), .QDEPTH(QDEPTH), .MVMVA_OP(6'h12)) u_dut (
    .i_clk(i_clk), .i_nRst(i_nRst), .i_instr(i_instr), .i_run(i_run),
    .o_ready(o_ready), .o_opcode(o_opcode), .i_startAdr(start_adr),
    .i_lastMicro(i_lastMicro), .i_stall(i_stall), .i_abort(i_abort),
    .o_PC(o_PC), .o_sf(o_sf), .o_lm(o_lm), .o_cv(o_cv), .o_vec(o_vec),
    .o_mx(o_mx), .o_isMVMVA(o_isMVMVA), .o_executing(o_executing),
    .o_lastCycles(o_lastCycles)
  );

  gte_sequencer #(.PC_W(4), .QDEPTH(QDEPTH), .MVMVA_OP(6'h12)) u_w4 (
    .i_clk(i_clk), .i_nRst(i_nRst), .i_instr(i_instr), .i_run(i_run),
    .o_ready(w4_ready), .o_opcode(w4_opcode), .i_startAdr(start_adr[3:0]),
    .i_lastMicro(i_lastMicro), .i_stall(i_stall), .i_abort(i_abort),
    .o_PC(w4_PC), .o_sf(w4_sf), .o_lm(w4_lm), .o_cv(w4_cv), .o_vec(w4_vec),
    .o_mx(w4_mx), .o_isMVMVA(w4_isMVMVA), .o_executing(w4_executing),
    .o_lastCycles(w4_lastCycles)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic logic [15:0] lc(input int v);
`ifdef GTE_SEQ_PERFCNT_EN
    return 16'(v);
`else
    return (v == v) ? 16'h0000 : 16'h0000;
`endif
  endfunction

  // ---------------- reference model ----------------
  logic [24:0] mq[$];
  bit          m_exec = 0;
  logic [8:0]  m_pc = '0;
  logic        m_sf = 0, m_lm = 0, m_mv = 0;
  logic [1:0]  m_cv = 0, m_vec = 0, m_mx = 0;
  int          m_cnt = 0;
  int          m_last = 0;

  // Compare at the falling edge, then advance the model to the next cycle
  always @(negedge i_clk) begin
    bit has_q, has_src, done, disp, push, e_rdy, e_ex;
    logic [24:0] src;
    logic [8:0]  e_pc;
    if (!i_nRst) begin
      mq.delete();
      m_exec = 0; m_pc = '0; m_cnt = 0; m_last = 0;
      m_sf = 0; m_lm = 0; m_mv = 0; m_cv = 0; m_vec = 0; m_mx = 0;
      chk("rst_pc", {23'd0, o_PC}, 32'd0);
      chk("rst_ready", {31'd0, o_ready}, 32'd0);
      chk("rst_exec", {31'd0, o_executing}, 32'd0);
      chk("rst_w4pc", {28'd0, w4_PC}, 32'd0);
    end else begin
      has_q   = (mq.size() > 0);
      has_src = has_q || i_run;
      src     = has_q ? mq[0] : i_instr;
      e_rdy   = (mq.size() < QDEPTH);
      done    = m_exec && i_lastMicro && !i_stall;
      disp    = has_src && (!m_exec || done) && !i_abort;
      if (i_abort)            e_pc = '0;
      else if (disp)          e_pc = rom(src[5:0]);
      else if (!m_exec)       e_pc = '0;
      else if (i_stall)       e_pc = m_pc;
      else if (!i_lastMicro)  e_pc = m_pc + 9'd1;
      else                    e_pc = '0;
      e_ex = (m_exec && !(done && !has_src)) || has_q;

      chk("pc", {23'd0, o_PC}, {23'd0, e_pc});
      chk("w4_pc", {28'd0, w4_PC}, {28'd0, e_pc[3:0]});
      chk("ready", {31'd0, o_ready}, {31'd0, e_rdy});
      chk("executing", {31'd0, o_executing}, {31'd0, e_ex});
      if (has_src) chk("opcode", {26'd0, o_opcode}, {26'd0, src[5:0]});
      chk("fields", {23'd0, o_sf, o_lm, o_mv_w(), o_cv, o_vec, o_mx},
                    {23'd0, m_sf, m_lm, m_mv, m_cv, m_vec, m_mx});
      chk("lastCycles", {16'd0, o_lastCycles}, {16'd0, lc(m_last)});

      if (i_abort) begin
        mq.delete();
        m_exec = 0;
      end else begin
        push = i_run && e_rdy && !(disp && !has_q);
        if (done) m_last = (m_cnt > 16'hFFFF) ? 16'hFFFF : m_cnt;
        if (disp) begin
          m_sf = src[19]; m_lm = src[10]; m_cv = src[14:13];
          m_vec = src[16:15]; m_mx = src[18:17]; m_mv = (src[5:0] == 6'h12);
          if (has_q) void'(mq.pop_front());
          m_exec = 1;
          m_cnt = 1;
        end else if (done) begin
          m_exec = 0;
        end else if (m_exec) begin
          m_cnt = (m_cnt >= 16'hFFFF) ? 16'hFFFF : m_cnt + 1;
        end
        if (push) mq.push_back(i_instr);
      end
      m_pc = e_pc;
    end
  end

  function automatic logic o_mv_w();
    return o_isMVMVA;
  endfunction

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic run, input logic [24:0] instr,
                       input logic last, input logic stall, input logic abort);
    @(posedge i_clk); #1;
    i_run = run; i_instr = instr; i_lastMicro = last;
    i_stall = stall; i_abort = abort;
    #2;
  endtask

  localparam logic [24:0] A  = 25'h000001;
  localparam logic [24:0] B  = 25'h000002;
  localparam logic [24:0] C  = 25'h000003;
  localparam logic [24:0] C2 = 25'h080003;
  localparam logic [24:0] D  = 25'h000004;
  localparam logic [24:0] E  = 25'h000005;
  localparam logic [24:0] G  = 25'h000006;
  localparam logic [24:0] M  = 25'h05A012;
  localparam logic [24:0] N  = 25'h080405;
  localparam logic [24:0] W  = 25'h08003F;

  initial begin
    #1;
    chk("lit_rst_pc", {23'd0, o_PC}, 32'h0);
    chk("lit_rst_ready", {31'd0, o_ready}, 32'h0);
    chk("lit_rst_fields", {25'd0, o_sf, o_lm, o_isMVMVA, o_cv, o_vec, o_mx}, 32'h0);
    @(posedge i_clk); @(posedge i_clk); #1;
    i_nRst = 1'b1;

    // single command, four microwords
    drive(1, A, 0, 0, 0);
    chk("lit_a_pc0", {23'd0, o_PC}, 32'h040);
    chk("lit_a_exec0", {31'd0, o_executing}, 32'h0);
    drive(0, '0, 0, 0, 0); chk("lit_a_pc1", {23'd0, o_PC}, 32'h041);
    chk("lit_a_exec1", {31'd0, o_executing}, 32'h1);
    drive(0, '0, 0, 0, 0); chk("lit_a_pc2", {23'd0, o_PC}, 32'h042);
    drive(0, '0, 0, 0, 0); chk("lit_a_pc3", {23'd0, o_PC}, 32'h043);
    drive(0, '0, 1, 0, 0); chk("lit_a_pc4", {23'd0, o_PC}, 32'h000);
    chk("lit_a_exec4", {31'd0, o_executing}, 32'h0);
    drive(0, '0, 0, 0, 0); chk("lit_a_lc", {16'd0, o_lastCycles}, {16'd0, lc(4)});

    // queue fills, third push refused, back-to-back dispatch
    drive(1, B, 0, 0, 0); chk("lit_q_pcB", {23'd0, o_PC}, 32'h015);
    drive(1, C, 0, 0, 0); chk("lit_q_rdy1", {31'd0, o_ready}, 32'h1);
    drive(1, D, 0, 0, 0); chk("lit_q_rdy2", {31'd0, o_ready}, 32'h1);
    drive(1, E, 0, 0, 0); chk("lit_q_rdy3", {31'd0, o_ready}, 32'h0);
    drive(0, '0, 1, 0, 0); chk("lit_q_pcC", {23'd0, o_PC}, 32'h01D);
    chk("lit_q_execC", {31'd0, o_executing}, 32'h1);
    drive(0, '0, 1, 0, 0); chk("lit_q_pcD", {23'd0, o_PC}, 32'h025);
    drive(0, '0, 0, 0, 0); chk("lit_q_pcD1", {23'd0, o_PC}, 32'h026);
    drive(0, '0, 1, 0, 0); chk("lit_q_end", {23'd0, o_PC}, 32'h000);
    drive(0, '0, 0, 0, 0); chk("lit_q_lc", {16'd0, o_lastCycles}, {16'd0, lc(2)});

    // stall at 041 overriding lastMicro
    drive(1, A, 0, 0, 0);
    drive(0, '0, 0, 0, 0); chk("lit_s_pc1", {23'd0, o_PC}, 32'h041);
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, 1, 1, 0); chk("lit_s_hold", {23'd0, o_PC}, 32'h041);
    end
    drive(0, '0, 1, 0, 0); chk("lit_s_end", {23'd0, o_PC}, 32'h000);
    drive(0, '0, 0, 0, 0); chk("lit_s_lc", {16'd0, o_lastCycles}, {16'd0, lc(5)});

    // MVMVA decode and field latching
    drive(1, M, 1, 0, 0); chk("lit_m_pc", {23'd0, o_PC}, 32'h100);
    drive(0, '0, 1, 0, 0);
    chk("lit_m_fields", {26'd0, o_isMVMVA, o_mx, o_vec, o_cv},
        {26'd0, 1'b1, 2'b10, 2'b11, 2'b01});
    drive(1, N, 0, 0, 0); chk("lit_m_hold", {31'd0, o_isMVMVA}, 32'h1);
    drive(0, '0, 1, 0, 0);
    chk("lit_n_fields", {25'd0, o_isMVMVA, o_sf, o_lm, o_mx, o_vec, o_cv},
        {25'd0, 1'b0, 1'b1, 1'b1, 6'd0});

    // push and pop together, then abort with a full queue and concurrent run
    drive(1, B, 0, 0, 0);
    drive(1, C2, 0, 0, 0);
    drive(1, D, 1, 0, 0); chk("lit_pp_pc", {23'd0, o_PC}, 32'h01D);
    drive(1, E, 0, 0, 0); chk("lit_pp_rdy", {31'd0, o_ready}, 32'h1);
    drive(1, G, 0, 0, 1); chk("lit_ab_pc", {23'd0, o_PC}, 32'h000);
    chk("lit_ab_rdy", {31'd0, o_ready}, 32'h0);
    drive(0, '0, 0, 0, 0);
    chk("lit_ab_pc1", {23'd0, o_PC}, 32'h000);
    chk("lit_ab_exec", {31'd0, o_executing}, 32'h0);
    chk("lit_ab_rdy1", {31'd0, o_ready}, 32'h1);
    chk("lit_ab_sf", {31'd0, o_sf}, 32'h1);
    chk("lit_ab_lc", {16'd0, o_lastCycles}, {16'd0, lc(2)});

    // PC wrap on both widths, then asynchronous reset mid-run
    drive(1, W, 0, 0, 0);
    chk("lit_w_pc", {23'd0, o_PC}, 32'h1FF);
    chk("lit_w4_pc", {28'd0, w4_PC}, 32'hF);
    drive(0, '0, 0, 0, 0);
    chk("lit_w_wrap", {23'd0, o_PC}, 32'h000);
    chk("lit_w4_wrap", {28'd0, w4_PC}, 32'h0);
    chk("lit_w_exec", {31'd0, o_executing}, 32'h1);
    drive(0, '0, 0, 0, 0);
    i_nRst = 1'b0;
    #1;
    chk("lit_ar_pc", {23'd0, o_PC}, 32'h0);
    chk("lit_ar_w4pc", {28'd0, w4_PC}, 32'h0);
    chk("lit_ar_rdy", {31'd0, o_ready}, 32'h0);
    chk("lit_ar_exec", {31'd0, o_executing}, 32'h0);
    chk("lit_ar_fields", {25'd0, o_sf, o_lm, o_isMVMVA, o_cv, o_vec, o_mx}, 32'h0);
    chk("lit_ar_w4sf", {31'd0, w4_sf}, 32'h0);
    i_lastMicro = 1'b1;
    @(posedge i_clk); @(posedge i_clk); #1;
    i_nRst = 1'b1;
    drive(0, '0, 0, 0, 0);
    chk("lit_ar_after_pc", {23'd0, o_PC}, 32'h0);
    chk("lit_ar_after_exec", {31'd0, o_executing}, 32'h0);
    chk("lit_ar_after_lc", {16'd0, o_lastCycles}, 32'h0);
    drive(0, '0, 0, 0, 0);
    drive(0, '0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
